// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with framebuffer read addressing.
// Sync/de/position outputs are delayed to line up with framebuffer read data.
module vga_timing_gen #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter bit HSYNC_POL   = 1'b0,
   parameter bit VSYNC_POL   = 1'b0,
   parameter int SCALE_SHIFT = 2,
   parameter int MEM_LATENCY = 1,
   parameter int CNT_W       = 12,
   parameter int ADDR_W      = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_en,
   output logic [ADDR_W-1:0] fb_addr,
   output logic              fb_rden,
   output logic              h_sync,
   output logic              v_sync,
   output logic              de,
   output logic [CNT_W-1:0]  pos_x,
   output logic [CNT_W-1:0]  pos_y,
   output logic              line_start,
   output logic              frame_start,
   output logic [15:0]       frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FRONT);
   localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FRONT);
   localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [CNT_W-1:0] Y_MASK = CNT_W'((1 << SCALE_SHIFT) - 1);
   localparam logic [ADDR_W-1:0] FB_W  = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

   typedef struct packed {
      logic             vld;
      logic             hs;
      logic             vs;
      logic             act;
      logic [CNT_W-1:0] hc;
      logic [CNT_W-1:0] vc;
   } tap_t;

   logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic              fb_rden_q, fb_rden_d;
   logic              shifted_q, shifted_d;
   logic [15:0]       frame_count_q, frame_count_d;
   tap_t              tap_q [0:MEM_LATENCY];
   tap_t              tap_d [0:MEM_LATENCY];

   logic              raw_hs, raw_vs, raw_act, line_act;
   logic [ADDR_W-1:0] x_word;
   tap_t              tap_out;

   assign raw_hs   = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
   assign raw_vs   = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
   assign line_act = (v_cnt_q < V_ACT);
   assign raw_act  = (h_cnt_q < H_ACT) && line_act;
   assign x_word   = ADDR_W'(h_cnt_q >> SCALE_SHIFT);

   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      row_base_d    = row_base_q;
      fb_addr_d     = fb_addr_q;
      fb_rden_d     = fb_rden_q;
      tap_d         = tap_q;
      shifted_d     = pix_en;
      frame_count_d = frame_count_q + 16'(frame_start);
      if (pix_en) begin
         fb_rden_d     = raw_act;
         fb_addr_d     = raw_act ? (row_base_q + x_word) : '0;
         tap_d[0].vld  = 1'b1;
         tap_d[0].hs   = raw_hs;
         tap_d[0].vs   = raw_vs;
         tap_d[0].act  = raw_act;
         tap_d[0].hc   = h_cnt_q;
         tap_d[0].vc   = v_cnt_q;
         for (int i = 1; i <= MEM_LATENCY; i++) begin
            tap_d[i] = tap_q[i-1];
         end
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d    = '0;
               row_base_d = '0;
            end else begin
               v_cnt_d = v_cnt_q + 1'b1;
               // advance one framebuffer row after each replicated line group
               if (line_act && ((v_cnt_q & Y_MASK) == Y_MASK)) begin
                  row_base_d = row_base_q + FB_W;
               end
            end
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         row_base_q    <= '0;
         fb_addr_q     <= '0;
         fb_rden_q     <= 1'b0;
         shifted_q     <= 1'b0;
         frame_count_q <= '0;
         for (int i = 0; i <= MEM_LATENCY; i++) begin
            tap_q[i] <= '0;
         end
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         row_base_q    <= row_base_d;
         fb_addr_q     <= fb_addr_d;
         fb_rden_q     <= fb_rden_d;
         shifted_q     <= shifted_d;
         frame_count_q <= frame_count_d;
         for (int i = 0; i <= MEM_LATENCY; i++) begin
            tap_q[i] <= tap_d[i];
         end
      end
   end

   assign tap_out     = tap_q[MEM_LATENCY];
   assign fb_addr     = fb_addr_q;
   assign fb_rden     = fb_rden_q;
   assign h_sync      = tap_out.hs ? HSYNC_POL : ~HSYNC_POL;
   assign v_sync      = tap_out.vs ? VSYNC_POL : ~VSYNC_POL;
   assign de          = tap_out.act;
   assign pos_x       = tap_out.act ? tap_out.hc : '0;
   assign pos_y       = tap_out.act ? tap_out.vc : '0;
   // pulses only in the clk right after the delay line moved
   assign line_start  = shifted_q && tap_out.vld && (tap_out.hc == '0);
   assign frame_start = line_start && (tap_out.vc == '0);
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two configurations driven in lockstep,
// expectations derived from the pixel index since reset.
module tb_vga_timing_gen;

   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int SS = 1;
   localparam int FBW = HA >> SS;

   typedef struct {
      logic        rden;
      logic [14:0] addr;
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] px;
      logic [11:0] py;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } exp_t;

   logic clk, rst, pix_en;

   logic [14:0] a_addr, b_addr;
   logic        a_rden, a_hs, a_vs, a_de, a_ls, a_fs;
   logic        b_rden, b_hs, b_vs, b_de, b_ls, b_fs;
   logic [11:0] a_px, a_py, b_px, b_py;
   logic [15:0] a_fc, b_fc;

   int vectors = 0;
   int miscompares = 0;

   exp_t qa[$];
   exp_t qb[$];

   int          n_steps;
   bit          shifted;
   logic [15:0] fc_a, fc_b;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
      .SCALE_SHIFT(SS), .MEM_LATENCY(2), .CNT_W(12), .ADDR_W(15)
   ) u_a (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .fb_addr(a_addr), .fb_rden(a_rden),
      .h_sync(a_hs), .v_sync(a_vs), .de(a_de),
      .pos_x(a_px), .pos_y(a_py),
      .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
      .SCALE_SHIFT(SS), .MEM_LATENCY(0), .CNT_W(12), .ADDR_W(15)
   ) u_b (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .fb_addr(b_addr), .fb_rden(b_rden),
      .h_sync(b_hs), .v_sync(b_vs), .de(b_de),
      .pos_x(b_px), .pos_y(b_py),
      .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // n = pixel steps taken since reset; register stage shows pixel n-1,
   // delayed outputs show pixel n-1-lat.
   function automatic exp_t model(int n, bit sh, int lat, bit hpol,
                                  bit vpol, logic [15:0] fc);
      exp_t e;
      int k, k2, h, v;
      e.rden = 1'b0; e.addr = '0; e.de = 1'b0;
      e.px = '0; e.py = '0; e.ls = 1'b0; e.fs = 1'b0;
      e.hs = ~hpol;
      e.vs = ~vpol;
      e.fc = fc;
      k = n - 1;
      if (k >= 0) begin
         h = k % HT;
         v = (k / HT) % VT;
         if (h < HA && v < VA) begin
            e.rden = 1'b1;
            e.addr = 15'((v >> SS) * FBW + (h >> SS));
         end
      end
      k2 = n - 1 - lat;
      if (k2 >= 0) begin
         h = k2 % HT;
         v = (k2 / HT) % VT;
         if (h >= HA + HF && h < HA + HF + HS) e.hs = hpol;
         if (v >= VA + VF && v < VA + VF + VS) e.vs = vpol;
         if (h < HA && v < VA) begin
            e.de = 1'b1;
            e.px = 12'(h);
            e.py = 12'(v);
         end
         e.ls = sh && (h == 0);
         e.fs = e.ls && (v == 0);
      end
      return e;
   endfunction

   task automatic step(input bit en, input bit r);
      exp_t ea, eb;
      @(negedge clk);
      pix_en = en;
      rst    = r;
      @(posedge clk);
      if (r) begin
         n_steps = 0;
         shifted = 1'b0;
         fc_a    = '0;
         fc_b    = '0;
      end else begin
         shifted = en;
         if (en) n_steps++;
      end
      ea = model(n_steps, shifted, 2, 1'b0, 1'b0, fc_a);
      eb = model(n_steps, shifted, 0, 1'b1, 1'b1, fc_b);
      if (ea.fs) fc_a = fc_a + 16'd1;
      if (eb.fs) fc_b = fc_b + 16'd1;
      qa.push_back(ea);
      qb.push_back(eb);
   endtask

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic check(input string tag, input exp_t a, input exp_t e);
      vectors++;
      cmp({tag, ".fb_rden"},     32'(a.rden), 32'(e.rden));
      cmp({tag, ".fb_addr"},     32'(a.addr), 32'(e.addr));
      cmp({tag, ".h_sync"},      32'(a.hs),   32'(e.hs));
      cmp({tag, ".v_sync"},      32'(a.vs),   32'(e.vs));
      cmp({tag, ".de"},          32'(a.de),   32'(e.de));
      cmp({tag, ".pos_x"},       32'(a.px),   32'(e.px));
      cmp({tag, ".pos_y"},       32'(a.py),   32'(e.py));
      cmp({tag, ".line_start"},  32'(a.ls),   32'(e.ls));
      cmp({tag, ".frame_start"}, 32'(a.fs),   32'(e.fs));
      cmp({tag, ".frame_count"}, 32'(a.fc),   32'(e.fc));
   endtask

   always @(negedge clk) begin
      exp_t e, a;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         a.rden = a_rden; a.addr = a_addr; a.hs = a_hs; a.vs = a_vs;
         a.de = a_de; a.px = a_px; a.py = a_py;
         a.ls = a_ls; a.fs = a_fs; a.fc = a_fc;
         check("lat2", a, e);
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         a.rden = b_rden; a.addr = b_addr; a.hs = b_hs; a.vs = b_vs;
         a.de = b_de; a.px = b_px; a.py = b_py;
         a.ls = b_ls; a.fs = b_fs; a.fc = b_fc;
         check("lat0", a, e);
      end
   end

   initial begin
      rst     = 1'b1;
      pix_en  = 1'b0;
      n_steps = 0;
      shifted = 1'b0;
      fc_a    = '0;
      fc_b    = '0;

      // reset, with pix_en high on one edge to show reset dominates
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);

      // continuous stepping over two full frames
      for (int i = 0; i < 2 * HT * VT + 20; i++) step(1'b1, 1'b0);

      // one-in-three enable from a fresh frame
      step(1'b0, 1'b1);
      for (int i = 0; i < 3 * (HT * VT + 20); i++) step(i % 3 == 0, 1'b0);

      // reset mid-frame at h_cnt 5, v_cnt 2, then a full frame afterwards
      step(1'b0, 1'b1);
      for (int i = 0; i < 2 * HT + 5; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      for (int i = 0; i < HT * VT + 20; i++) step(1'b1, 1'b0);

      // random enable with occasional resets
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 4) != 0, ($urandom % 400) == 0);
      end

      step(1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      if (qa.size() != 0 || qb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d/%0d expectations left, required 0",
                  qa.size(), qb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT, H_SYNC, H_BACK, defaults 16, 96, 48, horizontal porch/sync lengths in pixels.
REQ-003 SHALL have parameters V_ACTIVE, V_FRONT, V_SYNC, V_BACK, defaults 480, 10, 2, 33, vertical lengths in lines.
REQ-004 SHALL have parameters HSYNC_POL, VSYNC_POL, default 0, 0, asserted sync level (0 = active-low).
REQ-005 SHALL have parameter SCALE_SHIFT, default 2, framebuffer pixel replication 2^SCALE_SHIFT in x and y.
REQ-006 SHALL have parameter MEM_LATENCY, default 1, framebuffer read latency in pixel steps.
REQ-007 SHALL have parameters CNT_W, default 12, counter width; ADDR_W, default 15, framebuffer address width.
REQ-008 SHALL have port clk, input, 1, single clock for all logic.
REQ-009 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-010 SHALL have port pix_en, input, 1, pixel-step enable; one pixel per clk with pix_en high.
REQ-011 SHALL have ports fb_addr, output, ADDR_W, and fb_rden, output, 1, framebuffer read request.
REQ-012 SHALL have ports h_sync, v_sync, de, output, 1 each, sync and data-enable aligned to framebuffer data.
REQ-013 SHALL have ports pos_x, pos_y, output, CNT_W each, aligned active coordinates.
REQ-014 SHALL have ports line_start, frame_start, output, 1 each, one-clk pulses; frame_count, output, 16.

Function
REQ-015 SHALL keep h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1 (TOTAL = ACTIVE+FRONT+SYNC+BACK), advancing only on clk edges with pix_en high.
REQ-016 SHALL wrap h_cnt from H_TOTAL-1 to 0 and, on the same step, increment v_cnt, wrapping V_TOTAL-1 to 0.
REQ-017 SHALL order each line and frame as ACTIVE, FRONT, SYNC, BACK, starting at count 0.
REQ-018 SHALL define raw hsync asserted iff H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC; raw vsync the same using v_cnt and V_* parameters.
REQ-019 SHALL define raw active iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-020 SHALL register fb_rden = raw active and fb_addr = row_base + (h_cnt >> SCALE_SHIFT), or 0 when inactive, on the pix_en edge that samples (h_cnt, v_cnt).
REQ-021 SHALL compute row_base incrementally, with no multiplier: 0 at v_cnt 0; plus FB_W = H_ACTIVE >> SCALE_SHIFT at the end of every 2^SCALE_SHIFT-th active line; held through blanking.
REQ-022 SHALL truncate fb_addr to ADDR_W bits.
REQ-023 SHALL pass raw hsync, raw vsync, active, h_cnt and v_cnt through a MEM_LATENCY-stage delay line that shifts only on pix_en, so outputs trail fb_rden by MEM_LATENCY pixel steps.
REQ-024 SHALL drive h_sync = HSYNC_POL when delayed hsync is asserted, else ~HSYNC_POL; v_sync likewise with VSYNC_POL.
REQ-025 SHALL drive de = delayed active, and pos_x/pos_y = delayed h_cnt/v_cnt when de is high, else 0.
REQ-026 SHALL pulse line_start for one clk when the delayed output shows h_cnt = 0, and frame_start when it shows (0, 0).
REQ-027 SHALL increment frame_count, wrapping at 16 bits, on each frame_start pulse.
REQ-028 SHALL hold all outputs and state while pix_en is low; pulses SHALL NOT repeat.

Reset
REQ-029 SHALL, on rst high at a clk edge and regardless of pix_en, clear h_cnt, v_cnt, row_base, fb_addr, fb_rden, de, pos_x, pos_y, line_start, frame_start, frame_count and every delay stage to inactive, with syncs at the deasserted level.
REQ-030 SHALL treat the first pix_en step after rst falls as (0, 0) of a new frame; rst mid-line SHALL abandon the frame and SHALL produce no spurious pulse.

Verification
Use H=8/2/3/3 (H_TOTAL 16), V=4/1/2/1 (V_TOTAL 8), SCALE_SHIFT=1, MEM_LATENCY=2 unless noted.
REQ-031 SHALL check: rst then pix_en always high -> fb_rden high for steps 0-7; de high 2 steps later; h_sync low for h_cnt 10-12; line period 16 clks.
REQ-032 SHALL check the address sequence: fb_addr 0,0,1,1,2,2,3,3 on lines 0 and 1; 4,4,5,5,6,6,7,7 on lines 2 and 3; 0 during blanking.
REQ-033 SHALL check: v_sync low during lines 5-6; frame_start once per 128 pixel steps; frame_count 0 -> 1 -> 2 over two frames.
REQ-034 SHALL check: pix_en toggled 1-of-3 clks -> identical output sequence stretched 3x, with single-clk pulses.
REQ-035 SHALL check: rst asserted at h_cnt 5, v_cnt 2 -> next edge all outputs at reset values, frame_count 0; next frame restarts at fb_addr 0.
REQ-036 SHALL check: HSYNC_POL=1, VSYNC_POL=1, MEM_LATENCY=0 -> syncs active-high; de coincides with fb_rden.
